uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver. Generalises the fixed 9600-8N1 receiver with:
//   - configurable baud rate, oversampling, data width, parity and stop bits
//   - framing/parity/overrun error reporting, break detection
//   - valid/ready output handshake
//  Sits between the board RX pin and any byte-stream consumer (cmd parser, FIFO).
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency, Hz
//  BAUD       9600        line rate, bit/s
//  OSR        16          oversample ticks per bit; even, 8..32
//  DATA_BITS  8           data bits per frame, 5..9, LSB first
//  PARITY     0           0 none, 1 even, 2 odd
//  STOP_BITS  1           1 or 2
//  (local) TICK_DIV = CLK_HZ/(BAUD*OSR) - 1, truncated; >= 1 required
// PORTS
//  clk_i        in   1          system clock, all logic on rising edge
//  rst_n_i      in   1          asynchronous active-low reset
//  uart_rx_i    in   1          serial line, asynchronous, idle high
//  rx_data_o    out  DATA_BITS  received word; stable while rx_valid_o=1
//  rx_valid_o   out  1          word held in output register
//  rx_ready_i   in   1          consumer accepts word when valid & ready
//  rx_perr_o    out  1          parity error for held word; qualified by valid
//  rx_ferr_o    out  1          framing error (a stop bit sampled 0) for held word
//  rx_ovr_o     out  1          1-cycle pulse: completed frame dropped, register full
//  rx_brk_o     out  1          1-cycle pulse: break condition detected
//  rx_busy_o    out  1          1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset
//   - every output 0; both sync flops 1
//   - FSM IDLE, counters 0; reset mid-frame abandons the frame, nothing delivered
//  Input
//   - 2-FF synchroniser on uart_rx_i -> rxs
//   - tick counter 0..TICK_DIV gives a 1-cycle tick; runs only when FSM != IDLE
//   - counter restarts at 0 on start detect
//  Bit sampling
//   - per-bit tick index 0..OSR-1
//   - rxs captured at ticks OSR/2-1, OSR/2, OSR/2+1; bit value = 2-of-3 majority
//   - bit decided at tick OSR/2+1; bit boundary after tick OSR-1
//  FSM: IDLE, START, DATA, PAR, STOP, BRKW
//   - IDLE: rxs 1->0 edge -> START
//   - START: vote 1 -> IDLE (false start, no flag); else -> DATA
//   - DATA: shift DATA_BITS votes LSB first -> PAR if PARITY!=0, else STOP
//   - PAR: perr = XOR(data, parity bit) != (PARITY==2)
//   - STOP: 1 or 2 stop votes; any 0 sets ferr
//     * data, parity bit (if any) and all stop bits all 0 -> break: rx_brk_o pulse,
//       nothing delivered, -> BRKW
//     * otherwise: frame complete at decision of last stop bit -> IDLE immediately,
//       so the next start edge is seen within the same stop bit
//   - BRKW: wait for rxs=1 -> IDLE
//  Delivery, cycle after frame complete
//   - valid=0 or (valid & ready): load data/perr/ferr, valid=1
//   - valid=1 & ready=0: drop new frame, keep held word, rx_ovr_o pulses 1 cycle
//   - handshake: valid & ready clears valid next cycle unless a load happens that
//     same cycle (back-to-back)
//   - valid never drops without ready
//  Latency: rx_valid_o rises 1 clk after last stop-bit decision (~0.5+2/OSR bit
//   into the stop bit, plus 2 clk synchroniser)
// TESTING
//  T1 8N1 @9600, byte 0xA5, ready=1
//   -> one valid pulse, data=0xA5, perr=0, ferr=0, busy low after
//  T2 PARITY=1, 0x03 sent with parity bit 1 -> data=0x03, perr=1
//     same byte, parity bit 0 -> perr=0
//  T3 low glitch of OSR/4 ticks on idle line -> busy pulses, returns IDLE; no valid/brk
//  T4 0x5A with stop bit 0 -> valid, data=0x5A, ferr=1
//     line then held low 3 frames -> exactly one rx_brk_o pulse, no valid;
//     next 0x11 received clean
//  T5 ready=0, 0x01 then 0x02 -> held data 0x01, one rx_ovr_o pulse;
//     ready=1 -> 0x01 accepted, valid drops
//  T6 rst_n_i low mid-DATA of 0x77, release, send 0x3C
//     -> outputs 0 during reset; only 0x3C delivered
//  T7 DATA_BITS=7, STOP_BITS=2, PARITY=2, 2% baud skew, 0x00..0x7F sweep
//     -> all received, no errors

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer port: held word with status flags under valid/ready,
// plus overrun/break event pulses and a busy indication.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic                 rx_perr_o;
    logic                 rx_ferr_o;
    logic                 rx_ovr_o;
    logic                 rx_brk_o;
    logic                 rx_busy_o;

    modport master (
        output rx_data_o, rx_valid_o, rx_perr_o, rx_ferr_o, rx_ovr_o, rx_brk_o, rx_busy_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o, rx_valid_o, rx_perr_o, rx_ferr_o, rx_ovr_o, rx_brk_o, rx_busy_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver; word valid 1 clk after the last stop-bit vote.
// Backpressure: one held word; a frame completing while it is still unaccepted is dropped with rx_ovr_o.
module uart_rx_param #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            uart_rx_i,
    uart_rx_param_if.master rx_if
);
    localparam int TICK_DIV = CLK_HZ / (BAUD * OSR) - 1;
    localparam int TW       = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);
    localparam int OW       = $clog2(OSR);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV);
    localparam logic [OW-1:0] OS_LAST   = OW'(OSR - 1);
    localparam logic [OW-1:0] OS_S0     = OW'(OSR / 2 - 1);
    localparam logic [OW-1:0] OS_S1     = OW'(OSR / 2);
    localparam logic [OW-1:0] OS_DEC    = OW'(OSR / 2 + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY != 0);
    localparam logic          PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKW} state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] dat;
        logic                 perr;
        logic                 ferr;
    } frame_t;

    logic                 sync1_q, rxs_q, rxs_prev_q;
    state_t               state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [OW-1:0]        os_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic                 smp0_q, smp1_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_acc_q, ferr_acc_q, any_one_q;
    frame_t               frame_q, held_q;
    logic                 done_q, brk_q, vld_q, ovr_q;

    logic tick, decide, vote, perr_calc, load;

    assign tick      = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);
    assign decide    = tick && (os_cnt_q == OS_DEC);
    assign vote      = (smp0_q & smp1_q) | (smp0_q & rxs_q) | (smp1_q & rxs_q);
    assign perr_calc = PAR_EN && (par_acc_q != PAR_ODD);
    assign load      = done_q && (!vld_q || rx_if.rx_ready_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= uart_rx_i;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            smp0_q     <= 1'b1;
            smp1_q     <= 1'b1;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            ferr_acc_q <= 1'b0;
            any_one_q  <= 1'b0;
            frame_q    <= '0;
            done_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            brk_q  <= 1'b0;

            // Counters sit at zero in IDLE so a start edge always begins a fresh bit.
            if (state_q == IDLE) begin
                tick_cnt_q <= '0;
                os_cnt_q   <= '0;
            end else if (tick) begin
                tick_cnt_q <= '0;
                os_cnt_q   <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OW'(1);
            end else begin
                tick_cnt_q <= tick_cnt_q + TW'(1);
            end

            if (tick && os_cnt_q == OS_S0) smp0_q <= rxs_q;
            if (tick && os_cnt_q == OS_S1) smp1_q <= rxs_q;

            case (state_q)
                IDLE: begin
                    if (rxs_prev_q && !rxs_q) state_q <= START;
                end
                START: begin
                    if (decide) begin
                        if (vote) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= DATA;
                            bit_cnt_q  <= '0;
                            par_acc_q  <= 1'b0;
                            ferr_acc_q <= 1'b0;
                            any_one_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_q   <= {vote, shift_q[DATA_BITS-1:1]};
                        par_acc_q <= par_acc_q ^ vote;
                        any_one_q <= any_one_q | vote;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= PAR_EN ? PAR : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (decide) begin
                        par_acc_q <= par_acc_q ^ vote;
                        any_one_q <= any_one_q | vote;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (decide) begin
                        ferr_acc_q <= ferr_acc_q | ~vote;
                        any_one_q  <= any_one_q | vote;
                        if (bit_cnt_q == STOP_LAST) begin
                            // An all-zero frame is a break, not a word.
                            if (!(any_one_q | vote)) begin
                                brk_q   <= 1'b1;
                                state_q <= BRKW;
                            end else begin
                                done_q  <= 1'b1;
                                frame_q <= {shift_q, perr_calc, ferr_acc_q | ~vote};
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                BRKW: begin
                    if (rxs_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            held_q <= '0;
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= done_q && vld_q && !rx_if.rx_ready_i;
            if (load) begin
                held_q <= frame_q;
                vld_q  <= 1'b1;
            end else if (vld_q && rx_if.rx_ready_i) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data_o  = held_q.dat;
    assign rx_if.rx_valid_o = vld_q;
    assign rx_if.rx_perr_o  = held_q.perr;
    assign rx_if.rx_ferr_o  = held_q.ferr;
    assign rx_if.rx_ovr_o   = ovr_q;
    assign rx_if.rx_brk_o   = brk_q;
    assign rx_if.rx_busy_o  = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O2 with skewed sender)
// driven from a frame table and hand sequences, with a per-receiver expected-word queue.
module tb_uart_rx_param;
    localparam int CLK_HZ = 50_000_000;

    logic clk, rst_n;
    logic line_a, line_b, line_c;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(8)) if_b ();
    uart_rx_param_if #(.DATA_BITS(7)) if_c ();

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(1_562_500), .OSR(16), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1))
        u_a (.clk_i(clk), .rst_n_i(rst_n), .uart_rx_i(line_a), .rx_if(if_a));
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(1_562_500), .OSR(16), .DATA_BITS(8),
                    .PARITY(1), .STOP_BITS(1))
        u_b (.clk_i(clk), .rst_n_i(rst_n), .uart_rx_i(line_b), .rx_if(if_b));
    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(3_125_000), .OSR(8), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2))
        u_c (.clk_i(clk), .rst_n_i(rst_n), .uart_rx_i(line_c), .rx_if(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [8:0] dat;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        int         sel;
        logic [8:0] dat;
        logic       pbit;
        logic       stop;
        logic       perr;
        logic       ferr;
    } vec_t;

    exp_t sb0[$], sb1[$], sb2[$];
    int   checks;
    int   failures;
    int   brk_cnt [3];
    int   ovr_cnt [3];
    int   busy_cyc[3];

    // Line timing in clocks per bit x100; receiver C gets a 2% slow sender.
    function automatic int per_of(input int sel);
        return (sel == 2) ? 1632 : 3200;
    endfunction
    function automatic int nd_of(input int sel);
        return (sel == 2) ? 7 : 8;
    endfunction
    function automatic int ns_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    function automatic int sb_size(input int sel);
        case (sel)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic push(input int sel, input exp_t e);
        case (sel)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_word(input int sel, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        checks++;
        if (sb_size(sel) == 0) begin
            failures++;
            $display("FAIL unexpected_word dut%0d: got data=%0h perr=%b ferr=%b, none expected",
                     sel, d, pe, fe);
        end else begin
            case (sel)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            if ({d, pe, fe} !== e) begin
                failures++;
                $display("FAIL word dut%0d: got data=%0h perr=%b ferr=%b, expected data=%0h perr=%b ferr=%b",
                         sel, d, pe, fe, e.dat, e.perr, e.ferr);
            end
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       line_a = v;
            1:       line_b = v;
            default: line_c = v;
        endcase
    endtask

    task automatic idle(input int sel, input int nbits);
        repeat (nbits * per_of(sel) / 100) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input logic pb, input logic sv);
        logic [15:0] b;
        int          p;
        int          c;
        b    = '1;
        b[0] = 1'b0;
        p    = 1;
        for (int i = 0; i < nd_of(sel); i++) begin
            b[p] = d[i];
            p++;
        end
        if (sel != 0) begin
            b[p] = pb;
            p++;
        end
        for (int i = 0; i < ns_of(sel); i++) begin
            b[p] = sv;
            p++;
        end
        c = 0;
        for (int k = 0; k < p; k++) begin
            set_line(sel, b[k]);
            while (c * 100 < (k + 1) * per_of(sel)) begin
                @(negedge clk);
                c++;
            end
        end
        set_line(sel, 1'b1);
    endtask

    task automatic wait_drain(input int sel);
        int cyc;
        cyc = 0;
        while (sb_size(sel) != 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (sb_size(sel) != 0) begin
            failures++;
            $display("FAIL drain dut%0d: %0d words still outstanding after %0d cycles, expected 0",
                     sel, sb_size(sel), cyc);
        end
    endtask

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return if_a.rx_busy_o;
            1:       return if_b.rx_busy_o;
            default: return if_c.rx_busy_o;
        endcase
    endfunction

    initial begin
        vec_t       vecs [11];
        logic [8:0] d;
        int         b0, o0, bc0;

        checks   = 0;
        failures = 0;
        for (int i = 0; i < 3; i++) begin
            brk_cnt[i]  = 0;
            ovr_cnt[i]  = 0;
            busy_cyc[i] = 0;
        end
        rst_n  = 1'b0;
        line_a = 1'b1;
        line_b = 1'b1;
        line_c = 1'b1;
        if_a.rx_ready_i = 1'b1;
        if_b.rx_ready_i = 1'b1;
        if_c.rx_ready_i = 1'b1;

        vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{0, 9'h080, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1, 9'h003, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1, 9'h003, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h080, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1, 9'h07F, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1, 9'h0C3, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1, 9'h055, 1'b0, 1'b0, 1'b0, 1'b1};

        fork
            forever begin
                @(negedge clk);
                #1;
                if (rst_n) begin
                    if (if_a.rx_valid_o && if_a.rx_ready_i)
                        check_word(0, {1'b0, if_a.rx_data_o}, if_a.rx_perr_o, if_a.rx_ferr_o);
                    if (if_b.rx_valid_o && if_b.rx_ready_i)
                        check_word(1, {1'b0, if_b.rx_data_o}, if_b.rx_perr_o, if_b.rx_ferr_o);
                    if (if_c.rx_valid_o && if_c.rx_ready_i)
                        check_word(2, {2'b00, if_c.rx_data_o}, if_c.rx_perr_o, if_c.rx_ferr_o);
                    brk_cnt[0]  += int'(if_a.rx_brk_o);
                    brk_cnt[1]  += int'(if_b.rx_brk_o);
                    brk_cnt[2]  += int'(if_c.rx_brk_o);
                    ovr_cnt[0]  += int'(if_a.rx_ovr_o);
                    ovr_cnt[1]  += int'(if_b.rx_ovr_o);
                    ovr_cnt[2]  += int'(if_c.rx_ovr_o);
                    busy_cyc[0] += int'(if_a.rx_busy_o);
                end
            end
            begin
                repeat (90000) @(posedge clk);
                $display("FAIL watchdog: bench did not complete within 90000 cycles");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_data", if_a.rx_data_o, 0);
        chk("reset_valid", if_a.rx_valid_o, 0);
        chk("reset_perr", if_a.rx_perr_o, 0);
        chk("reset_ferr", if_a.rx_ferr_o, 0);
        chk("reset_ovr", if_a.rx_ovr_o, 0);
        chk("reset_brk", if_a.rx_brk_o, 0);
        chk("reset_busy", if_a.rx_busy_o, 0);
        chk("reset_busy_c", if_c.rx_busy_o, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            push(vecs[i].sel, {vecs[i].dat, vecs[i].perr, vecs[i].ferr});
            send_frame(vecs[i].sel, vecs[i].dat, vecs[i].pbit, vecs[i].stop);
            idle(vecs[i].sel, 2);
            wait_drain(vecs[i].sel);
            chk("busy_after_frame", busy_of(vecs[i].sel), 0);
        end

        // Short low glitch on an idle line: false start only.
        b0  = brk_cnt[0];
        bc0 = busy_cyc[0];
        line_a = 1'b0;
        repeat (8) @(negedge clk);
        line_a = 1'b1;
        idle(0, 3);
        chk("glitch_busy_seen", busy_cyc[0] > bc0, 1);
        chk("glitch_busy_after", if_a.rx_busy_o, 0);
        chk("glitch_no_brk", brk_cnt[0] - b0, 0);

        // Framing error word, then a long low line giving exactly one break.
        push(0, {9'h05A, 1'b0, 1'b1});
        send_frame(0, 9'h05A, 1'b0, 1'b0);
        idle(0, 2);
        wait_drain(0);
        b0 = brk_cnt[0];
        line_a = 1'b0;
        repeat (3 * 10 * 32) @(negedge clk);
        line_a = 1'b1;
        idle(0, 2);
        chk("break_pulses", brk_cnt[0] - b0, 1);
        chk("break_busy_after", if_a.rx_busy_o, 0);
        push(0, {9'h011, 1'b0, 1'b0});
        send_frame(0, 9'h011, 1'b0, 1'b1);
        idle(0, 2);
        wait_drain(0);

        // Overrun: second word dropped while the first is held.
        if_a.rx_ready_i = 1'b0;
        o0 = ovr_cnt[0];
        push(0, {9'h001, 1'b0, 1'b0});
        send_frame(0, 9'h001, 1'b0, 1'b1);
        idle(0, 1);
        send_frame(0, 9'h002, 1'b0, 1'b1);
        idle(0, 2);
        chk("ovr_pulses", ovr_cnt[0] - o0, 1);
        chk("ovr_valid_held", if_a.rx_valid_o, 1);
        chk("ovr_data_held", if_a.rx_data_o, 8'h01);
        if_a.rx_ready_i = 1'b1;
        wait_drain(0);
        repeat (2) @(negedge clk);
        chk("ovr_valid_dropped", if_a.rx_valid_o, 0);

        // Reset in the middle of a data field abandons that frame.
        fork
            send_frame(0, 9'h077, 1'b0, 1'b1);
            begin
                repeat (128) @(negedge clk);
                chk("midframe_busy", if_a.rx_busy_o, 1);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                chk("midreset_data", if_a.rx_data_o, 0);
                chk("midreset_valid", if_a.rx_valid_o, 0);
                chk("midreset_busy", if_a.rx_busy_o, 0);
                chk("midreset_ferr", if_a.rx_ferr_o, 0);
            end
        join
        idle(0, 2);
        rst_n = 1'b1;
        idle(0, 1);
        push(0, {9'h03C, 1'b0, 1'b0});
        send_frame(0, 9'h03C, 1'b0, 1'b1);
        idle(0, 2);
        wait_drain(0);

        // 7O2 sweep, back-to-back frames from a 2% slow sender.
        for (int v = 0; v < 128; v++) begin
            d = 9'(v);
            push(2, {d, 1'b0, 1'b0});
            send_frame(2, d, ~^d[6:0], 1'b1);
        end
        idle(2, 2);
        wait_drain(2);

        chk("total_brk_a", brk_cnt[0], 1);
        chk("total_ovr_a", ovr_cnt[0], 1);
        chk("total_brk_b", brk_cnt[1], 0);
        chk("total_ovr_b", ovr_cnt[1], 0);
        chk("total_brk_c", brk_cnt[2], 0);
        chk("total_ovr_c", ovr_cnt[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
